// File: rtl/rt_array_seq_pkg.sv
// rt_array_pkg: plane codes, FSM states and shared constants for rt_array_seq
package rt_array_pkg;

    typedef enum logic [1:0] {PLANE_DATA, PLANE_MASK, PLANE_PROG, PLANE_ILL} plane_e;
    typedef enum logic [1:0] {IDLE, SHIFT, ACCESS, RESP} state_e;

    localparam int SHIFT_CNT_W = 32;
    localparam int NPLANE      = 3;

endpackage

// File: rtl/rt_array_seq_if.sv
// rt_array_seq_if: request/response handshake and shift-status bundle for rt_array_seq
interface rt_array_seq_if #(parameter int W = 32, parameter int RW = 5, parameter int PW = 3);

    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [1:0]    req_plane;
    logic [RW-1:0] req_row;
    logic [PW-1:0] req_pos;
    logic [W-1:0]  req_wdata;
    logic [W-1:0]  req_wmask;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [W-1:0]  rsp_rdata;
    logic          rsp_err;
    logic          shift_en;
    logic          shift_dir;
    logic [PW-1:0] pos;

    modport master (
        output req_valid, req_we, req_plane, req_row, req_pos, req_wdata, req_wmask, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, shift_en, shift_dir, pos
    );

    modport slave (
        input  req_valid, req_we, req_plane, req_row, req_pos, req_wdata, req_wmask, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, shift_en, shift_dir, pos
    );

endinterface

// File: rtl/rt_array_seq_shift_ctrl.sv
// rt_shift_ctrl: moves the shared access port one domain per cycle toward a target
module rt_shift_ctrl #(
    parameter int NP = 8,
    parameter int PW = $clog2(NP)
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    input  logic          start_i,
    input  logic [PW-1:0] tgt_i,
    output logic [PW-1:0] pos_o,
    output logic          shift_en_o,
    output logic          shift_dir_o,
    output logic          done_o
);

    logic [PW-1:0] pos_q, pos_d, tgt_q, tgt_d;
    logic          en_q, en_d, dir_q, dir_d;

    // next position and shift state; done fires in the cycle whose shift lands on the target
    always_comb begin
        pos_d  = en_q ? (dir_q ? pos_q + PW'(1) : pos_q - PW'(1)) : pos_q;
        done_o = en_q && (pos_d == tgt_q);
        tgt_d  = start_i ? tgt_i : tgt_q;
        en_d   = start_i ? (tgt_i != pos_q) : (en_q && !done_o);
        dir_d  = start_i ? (tgt_i > pos_q) : dir_q;
    end

    // shift state registers
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            pos_q <= '0;
            tgt_q <= '0;
            en_q  <= 1'b0;
            dir_q <= 1'b0;
        end else begin
            pos_q <= pos_d;
            tgt_q <= tgt_d;
            en_q  <= en_d;
            dir_q <= dir_d;
        end
    end

    assign pos_o       = pos_q;
    assign shift_en_o  = en_q;
    assign shift_dir_o = dir_q;

endmodule

// File: rtl/rt_array_seq.sv
// rt_array_seq: request-driven racetrack array with shift/access FSM; RT_SHIFT_CNT_EN adds shift_cnt_o
module rt_array_seq
    import rt_array_pkg::*;
#(
    parameter int NMU = 8,
    parameter int NR  = 4,
    parameter int NB  = 32,
    parameter int NP  = 8
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
`ifdef RT_SHIFT_CNT_EN
    output logic [SHIFT_CNT_W-1:0] shift_cnt_o,
`endif
    rt_array_seq_if.slave          bus
);

    localparam int W  = NMU * NR;
    localparam int RW = $clog2(NB);
    localparam int PW = $clog2(NP);

    state_e        state_q, state_d;
    plane_e        plane_q, plane_d;
    logic          we_q, we_d, err_q, err_d, rdy_q, rdy_d, vld_q, vld_d;
    logic [RW-1:0] row_q, row_d;
    logic [W-1:0]  wdata_q, wdata_d, wmask_q, wmask_d, rdata_q, rdata_d;
    logic [W-1:0]  mem_q [NPLANE][NB][NP];
    logic [W-1:0]  old_w, new_w;
    logic [PW-1:0] pos;
    logic          ill, start, wr_en, done, shift_en;

    rt_shift_ctrl #(.NP(NP), .PW(PW)) u_shift (
        .clk_i      (clk_i),
        .rstn_i     (rstn_i),
        .start_i    (start),
        .tgt_i      (bus.req_pos),
        .pos_o      (pos),
        .shift_en_o (shift_en),
        .shift_dir_o(bus.shift_dir),
        .done_o     (done)
    );

    // request decode, FSM next state and response data; an illegal request still
    // passes through ACCESS (with writes suppressed) so every response has the d=0 latency
    always_comb begin
        state_d = state_q;
        plane_d = plane_q;
        we_d    = we_q;
        row_d   = row_q;
        wdata_d = wdata_q;
        wmask_d = wmask_q;
        err_d   = err_q;
        rdy_d   = rdy_q;
        vld_d   = vld_q;
        rdata_d = rdata_q;
        wr_en   = 1'b0;
        ill     = plane_e'(bus.req_plane) == PLANE_ILL || 32'(bus.req_row) >= 32'(NB)
                  || 32'(bus.req_pos) >= 32'(NP);
        start   = state_q == IDLE && bus.req_valid && !ill;
        old_w   = mem_q[plane_q][row_q][pos];
        new_w   = we_q ? (old_w & ~wmask_q) | (wdata_q & wmask_q) : old_w;
        case (state_q)
            IDLE: if (bus.req_valid) begin
                we_d    = bus.req_we;
                plane_d = ill ? PLANE_DATA : plane_e'(bus.req_plane);
                row_d   = ill ? '0 : bus.req_row;
                wdata_d = bus.req_wdata;
                wmask_d = bus.req_wmask;
                err_d   = ill;
                rdy_d   = 1'b0;
                state_d = (!ill && bus.req_pos != pos) ? SHIFT : ACCESS;
            end
            SHIFT: state_d = done ? ACCESS : SHIFT;
            ACCESS: begin
                wr_en   = we_q && !err_q;
                rdata_d = err_q ? '0 : new_w;
                vld_d   = 1'b1;
                state_d = RESP;
            end
            RESP: if (bus.rsp_ready) begin
                vld_d   = 1'b0;
                rdy_d   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state, latched request and registered handshake outputs
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
            plane_q <= PLANE_DATA;
            we_q    <= 1'b0;
            row_q   <= '0;
            wdata_q <= '0;
            wmask_q <= '0;
            err_q   <= 1'b0;
            rdy_q   <= 1'b1;
            vld_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            plane_q <= plane_d;
            we_q    <= we_d;
            row_q   <= row_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
            err_q   <= err_d;
            rdy_q   <= rdy_d;
            vld_q   <= vld_d;
            rdata_q <= rdata_d;
        end
    end

    // racetrack storage: one word per plane/row/domain, all cleared by reset
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) mem_q <= '{default: '0};
        else if (wr_en) mem_q[plane_q][row_q][pos] <= new_w;
    end

`ifdef RT_SHIFT_CNT_EN
    logic [SHIFT_CNT_W-1:0] cnt_q, cnt_d;

    // saturating count of shift cycles since reset
    always_comb cnt_d = (shift_en && !(&cnt_q)) ? cnt_q + SHIFT_CNT_W'(1) : cnt_q;

    // shift counter register
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end

    assign shift_cnt_o = cnt_q;
`endif

    assign bus.req_ready = rdy_q;
    assign bus.rsp_valid = vld_q;
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
    assign bus.shift_en  = shift_en;
    assign bus.pos       = pos;

endmodule
